// File: rtl/toggle_activity_monitor_if.sv
// Control, probe and result-stream signals of the toggle activity monitor.
// The master side drives run control, probe samples and result back-pressure.
// The slave side (the monitor itself) returns status and the result entries.
interface toggle_activity_monitor_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) ();

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             start;
  logic             abort;
  logic [WIN_W-1:0] win_len;
  logic [WIDTH-1:0] sample;
  logic             sample_en;
  logic             busy;
  logic             done;
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_idx;
  logic [CNT_W-1:0] res_count;
  logic             res_sat;
  logic             res_last;

  modport master (
    output start, abort, win_len, sample, sample_en, res_ready,
    input  busy, done, res_valid, res_idx, res_count, res_sat, res_last
  );

  modport slave (
    input  start, abort, win_len, sample, sample_en, res_ready,
    output busy, done, res_valid, res_idx, res_count, res_sat, res_last
  );

endinterface

// File: rtl/toggle_activity_monitor.sv
// Per-bit toggle counter for a probe vector over a window of win_len transitions.
// Flow: IDLE -> PRIME (load first sample) -> COUNT (win_len transitions) -> DRAIN
// (stream one entry per bit) -> IDLE. Counters saturate and flag the saturation.
// abort returns to IDLE from any state without a done pulse and leaves counts intact.
module toggle_activity_monitor #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  toggle_activity_monitor_if.slave         bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_COUNT = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_nextState;
  logic [WIN_W-1:0]          r_winLen;
  logic [WIN_W-1:0]          r_nTrans;
  logic [WIDTH-1:0]          r_prev;
  logic [WIDTH-1:0]          r_sat;
  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_busy;
  logic                      r_resValid;
  logic                      r_done;

  logic                      w_accept;
  logic                      w_windowEnd;
  logic                      w_handshake;
  logic                      w_lastHandshake;
  logic [WIDTH-1:0]          w_toggle;
  logic [CNT_W-1:0]          w_selCnt;
  logic                      w_selSat;

  assign w_accept        = (r_state == S_IDLE) && bus.start && (bus.win_len != '0);
  assign w_windowEnd     = (r_state == S_COUNT) && bus.sample_en &&
                           ((r_nTrans + WIN_W'(1)) == r_winLen);
  assign w_handshake     = (r_state == S_DRAIN) && bus.res_ready;
  assign w_lastHandshake = w_handshake && (r_idx == LAST_IDX);
  assign w_toggle        = bus.sample ^ r_prev;

  // Next-state decode; abort overrides everything and drops straight to IDLE.
  always_comb begin
    w_nextState = r_state;
    if (bus.abort) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept)        w_nextState = S_PRIME;
        S_PRIME: if (bus.sample_en)   w_nextState = S_COUNT;
        S_COUNT: if (w_windowEnd)     w_nextState = S_DRAIN;
        S_DRAIN: if (w_lastHandshake) w_nextState = S_IDLE;
        default:                      w_nextState = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Registered status flags decoded from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_resValid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy     <= (w_nextState != S_IDLE);
      r_resValid <= (w_nextState == S_DRAIN);
      r_done     <= w_lastHandshake && !bus.abort;
    end
  end

  // Result index: starts at 0 on entering DRAIN, steps on each accepted entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if ((r_state == S_DRAIN) && (w_nextState == S_DRAIN)) begin
      if (w_handshake) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end else begin
      r_idx <= '0;
    end
  end

  // Window bookkeeping: clear on accepted start, prime prev, then count toggles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_winLen <= '0;
      r_nTrans <= '0;
      r_prev   <= '0;
      r_sat    <= '0;
      r_cnt    <= '0;
    end else if (!bus.abort) begin
      if (w_accept) begin
        r_winLen <= bus.win_len;
        r_nTrans <= '0;
        r_sat    <= '0;
        r_cnt    <= '0;
      end else if ((r_state == S_PRIME) && bus.sample_en) begin
        r_prev <= bus.sample;
      end else if ((r_state == S_COUNT) && bus.sample_en) begin
        r_prev   <= bus.sample;
        r_nTrans <= r_nTrans + WIN_W'(1);
        for (int i = 0; i < WIDTH; i++) begin
          if (w_toggle[i]) begin
            if (r_cnt[i] == CNT_MAX) begin
              r_sat[i] <= 1'b1;
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  // Select the counter and sticky flag for the current entry; zero when no entry is offered.
  always_comb begin
    w_selCnt = '0;
    w_selSat = 1'b0;
    if (r_resValid) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_idx == IDX_W'(i)) begin
          w_selCnt = r_cnt[i];
          w_selSat = r_sat[i];
        end
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.res_valid = r_resValid;
  assign bus.res_idx   = r_idx;
  assign bus.res_count = w_selCnt;
  assign bus.res_sat   = w_selSat;
  assign bus.res_last  = r_resValid && (r_idx == LAST_IDX);

endmodule
